// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with wrap-bit pointers and registered status flags.
// Optional sticky overflow/underflow flags are enabled by defining SYNC_FIFO_ERR_EN.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        tx_ready,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        rx_ready,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  output logic                        fifo_f,
  output logic                        fifo_e,
  output logic                        fifo_af,
  output logic                        fifo_ae,
  output logic [$clog2(DEPTH):0]      fifo_cnt,
  input  logic                        err_clr,
  output logic                        ovf,
  output logic                        udf
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              f_q, f_d, e_q, e_d, af_q, af_d, ae_q, ae_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, rd_acc;

  // Acceptance looks only at registered flags, so full/empty collisions resolve without fall-through.
  always_comb begin
    wr_acc     = tx_ready && !f_q;
    rd_acc     = rx_ready && !e_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ONE;
      rx_data_d  = mem[rd_ptr_q[ADDR_W-1:0]];
      rx_valid_d = 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
    f_d  = (cnt_d == CNT_FULL);
    e_d  = (cnt_d == '0);
    af_d = (cnt_d >= AF_LVL);
    ae_d = (cnt_d <= AE_LVL);
  end

`ifdef SYNC_FIFO_ERR_EN
  // Set is applied after clear so a simultaneous set wins.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (tx_ready && f_q) ovf_d = 1'b1;
    if (rx_ready && e_q) udf_d = 1'b1;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  always_comb begin
    ovf_d = 1'b0;
    udf_d = 1'b0;
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      f_q        <= 1'b0;
      e_q        <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      f_q        <= f_d;
      e_q        <= e_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is not reset; reset only blocks a same-cycle write.
  always_ff @(posedge sys_clk) begin
    if (rst_n && wr_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= tx_data;
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign fifo_f   = f_q;
  assign fifo_e   = e_q;
  assign fifo_af  = af_q;
  assign fifo_ae  = ae_q;
  assign fifo_cnt = cnt_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (8x8); error-flag expectations follow SYNC_FIFO_ERR_EN.
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       rst_n, tx_ready, rx_ready, err_clr;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, fifo_f, fifo_e, fifo_af, fifo_ae, ovf, udf;
  logic [3:0] fifo_cnt;
  int         total = 0;
  int         bad = 0;

  always #5 sys_clk = ~sys_clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(8)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_f(fifo_f), .fifo_e(fifo_e), .fifo_af(fifo_af), .fifo_ae(fifo_ae),
    .fifo_cnt(fifo_cnt), .err_clr(err_clr), .ovf(ovf), .udf(udf)
  );

  // {full, empty, almost_full, almost_empty, count} for an 8-deep FIFO, AF=7, AE=1
  function automatic logic [7:0] exp_st(input int c);
    exp_st = {c == 8, c == 0, c >= 7, c <= 1, 4'(c)};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle();
    tx_ready = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_data = 8'h00; idle();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({fifo_f, fifo_e, fifo_af, fifo_ae, fifo_cnt} !== exp_st(0)) begin
      bad++; $display("FAIL reset_status got %b exp %b", {fifo_f, fifo_e, fifo_af, fifo_ae, fifo_cnt}, exp_st(0));
    end
    total++;
    if ({rx_valid, rx_data, ovf, udf} !== 11'h000) begin
      bad++; $display("FAIL reset_outputs got valid=%b data=%h ovf=%b udf=%b exp 0 00 0 0", rx_valid, rx_data, ovf, udf);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      tx_ready = 1'b1; tx_data = 8'h10 + 8'(i);
      tick();
      total++;
      if ({fifo_f, fifo_e, fifo_af, fifo_ae, fifo_cnt} !== exp_st(i + 1)) begin
        bad++; $display("FAIL fill_status[%0d] got %b exp %b", i, {fifo_f, fifo_e, fifo_af, fifo_ae, fifo_cnt}, exp_st(i + 1));
      end
    end
    tx_data = 8'hFF;
    tick();
    total++;
    if ({fifo_f, fifo_cnt, ovf} !== {1'b1, 4'd8, ERR}) begin
      bad++; $display("FAIL overfill got f=%b cnt=%0d ovf=%b exp 1 8 %b", fifo_f, fifo_cnt, ovf, ERR);
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      rx_ready = 1'b1;
      tick();
      total++;
      if ({rx_valid, rx_data, fifo_cnt} !== {1'b1, 8'h10 + 8'(i), 4'(7 - i)}) begin
        bad++; $display("FAIL drain[%0d] got valid=%b data=%h cnt=%0d exp 1 %h %0d", i, rx_valid, rx_data, fifo_cnt, 8'h10 + 8'(i), 7 - i);
      end
    end
    idle();
    tick();
    total++;
    if ({rx_valid, rx_data, fifo_e} !== {1'b0, 8'h17, 1'b1}) begin
      bad++; $display("FAIL drain_idle got valid=%b data=%h e=%b exp 0 17 1", rx_valid, rx_data, fifo_e);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got %b exp 0", ovf);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      tx_ready = 1'b1; tx_data = 8'h50 + 8'(i); tick();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      rx_ready = 1'b1; tick();
      total++;
      if ({rx_valid, rx_data} !== {1'b1, 8'h50 + 8'(i)}) begin
        bad++; $display("FAIL wrap_pre[%0d] got valid=%b data=%h exp 1 %h", i, rx_valid, rx_data, 8'h50 + 8'(i));
      end
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      tx_ready = 1'b1; tx_data = 8'hA0 + 8'(i); tick();
    end
    idle();
    total++;
    if ({fifo_f, fifo_e, fifo_af, fifo_ae, fifo_cnt} !== exp_st(8)) begin
      bad++; $display("FAIL wrap_full got %b exp %b", {fifo_f, fifo_e, fifo_af, fifo_ae, fifo_cnt}, exp_st(8));
    end
    for (int i = 0; i < 8; i++) begin
      rx_ready = 1'b1; tick();
      total++;
      if ({rx_valid, rx_data} !== {1'b1, 8'hA0 + 8'(i)}) begin
        bad++; $display("FAIL wrap_read[%0d] got valid=%b data=%h exp 1 %h", i, rx_valid, rx_data, 8'hA0 + 8'(i));
      end
    end
    idle();
    tick();
    total++;
    if ({fifo_f, fifo_e, fifo_af, fifo_ae, fifo_cnt} !== exp_st(0)) begin
      bad++; $display("FAIL wrap_empty got %b exp %b", {fifo_f, fifo_e, fifo_af, fifo_ae, fifo_cnt}, exp_st(0));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      tx_ready = 1'b1; tx_data = 8'h30 + 8'(i); tick();
    end
    for (int i = 0; i < 2; i++) begin
      tx_ready = 1'b1; rx_ready = 1'b1; tx_data = 8'h33 + 8'(i); tick();
      total++;
      if ({rx_valid, rx_data, fifo_cnt} !== {1'b1, 8'h30 + 8'(i), 4'd3}) begin
        bad++; $display("FAIL both_mid[%0d] got valid=%b data=%h cnt=%0d exp 1 %h 3", i, rx_valid, rx_data, fifo_cnt, 8'h30 + 8'(i));
      end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      rx_ready = 1'b1; tick();
      total++;
      if ({rx_valid, rx_data} !== {1'b1, 8'h32 + 8'(i)}) begin
        bad++; $display("FAIL both_mid_tail[%0d] got valid=%b data=%h exp 1 %h", i, rx_valid, rx_data, 8'h32 + 8'(i));
      end
    end
    idle();
  endtask

  task automatic test_both_full();
    for (int i = 0; i < 8; i++) begin
      tx_ready = 1'b1; tx_data = 8'hC0 + 8'(i); tick();
    end
    tx_ready = 1'b1; rx_ready = 1'b1; tx_data = 8'hEE;
    tick();
    total++;
    if ({rx_valid, rx_data, fifo_cnt, fifo_f, ovf} !== {1'b1, 8'hC0, 4'd7, 1'b0, ERR}) begin
      bad++; $display("FAIL both_full got valid=%b data=%h cnt=%0d f=%b ovf=%b exp 1 c0 7 0 %b", rx_valid, rx_data, fifo_cnt, fifo_f, ovf, ERR);
    end
    idle();
    for (int i = 1; i < 8; i++) begin
      rx_ready = 1'b1; tick();
      total++;
      if ({rx_valid, rx_data} !== {1'b1, 8'hC0 + 8'(i)}) begin
        bad++; $display("FAIL both_full_tail[%0d] got valid=%b data=%h exp 1 %h", i, rx_valid, rx_data, 8'hC0 + 8'(i));
      end
    end
    idle(); err_clr = 1'b1; tick(); idle();
  endtask

  task automatic test_both_empty();
    tx_ready = 1'b1; rx_ready = 1'b1; tx_data = 8'h77;
    tick();
    total++;
    if ({rx_valid, rx_data, fifo_cnt, fifo_e, udf} !== {1'b0, 8'hC7, 4'd1, 1'b0, ERR}) begin
      bad++; $display("FAIL both_empty got valid=%b data=%h cnt=%0d e=%b udf=%b exp 0 c7 1 0 %b", rx_valid, rx_data, fifo_cnt, fifo_e, udf, ERR);
    end
    idle(); rx_ready = 1'b1;
    tick();
    total++;
    if ({rx_valid, rx_data, fifo_e} !== {1'b1, 8'h77, 1'b1}) begin
      bad++; $display("FAIL both_empty_read got valid=%b data=%h e=%b exp 1 77 1", rx_valid, rx_data, fifo_e);
    end
  endtask

  task automatic test_underflow();
    rx_ready = 1'b1; err_clr = 1'b1;
    tick();
    total++;
    if ({rx_valid, rx_data, udf} !== {1'b0, 8'h77, ERR}) begin
      bad++; $display("FAIL udf_set_wins got valid=%b data=%h udf=%b exp 0 77 %b", rx_valid, rx_data, udf, ERR);
    end
    err_clr = 1'b0;
    tick();
    total++;
    if ({rx_valid, rx_data, udf} !== {1'b0, 8'h77, ERR}) begin
      bad++; $display("FAIL udf_sticky got valid=%b data=%h udf=%b exp 0 77 %b", rx_valid, rx_data, udf, ERR);
    end
    idle(); err_clr = 1'b1;
    tick();
    idle();
    total++;
    if (udf !== 1'b0) begin
      bad++; $display("FAIL udf_clear got %b exp 0", udf);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      tx_ready = 1'b1; tx_data = 8'h60 + 8'(i); tick();
    end
    total++;
    if (fifo_cnt !== 4'd5) begin
      bad++; $display("FAIL mid_pre_cnt got %0d exp 5", fifo_cnt);
    end
    rst_n = 1'b0; tx_data = 8'h99;
    tick();
    total++;
    if ({fifo_f, fifo_e, fifo_af, fifo_ae, fifo_cnt} !== exp_st(0) || rx_data !== 8'h00) begin
      bad++; $display("FAIL mid_reset got %b data=%h exp %b 00", {fifo_f, fifo_e, fifo_af, fifo_ae, fifo_cnt}, rx_data, exp_st(0));
    end
    rst_n = 1'b1; idle(); rx_ready = 1'b1;
    tick();
    total++;
    if ({rx_valid, fifo_cnt, fifo_e} !== {1'b0, 4'd0, 1'b1}) begin
      bad++; $display("FAIL mid_after got valid=%b cnt=%0d e=%b exp 0 0 1", rx_valid, fifo_cnt, fifo_e);
    end
    idle(); err_clr = 1'b1; tx_ready = 1'b1; tx_data = 8'h42;
    tick();
    idle(); rx_ready = 1'b1;
    tick();
    idle();
    total++;
    if ({rx_valid, rx_data, fifo_cnt} !== {1'b1, 8'h42, 4'd0}) begin
      bad++; $display("FAIL mid_reuse got valid=%b data=%h cnt=%0d exp 1 42 0", rx_valid, rx_data, fifo_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_both_full();
    test_both_empty();
    test_underflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO buffering bytes (or wider words) between the system-side producer and the SPI-side consumer logic, both of which run in the `sys_clk` domain. It generalises the existing 8x8 buffer with configurable width, depth and almost-full/almost-empty thresholds. It uses a circular buffer with wrap-bit pointers instead of shifting storage, and gives deterministic handling of simultaneous and illegal requests.

## Interface
- `DATA_W`, 8, word width in bits.
- `DEPTH`, 8, number of entries; power of two, at least 2.
- `AF_LEVEL`, DEPTH-1, `fifo_af` asserts when occupancy is at least this value.
- `AE_LEVEL`, 1, `fifo_ae` asserts when occupancy is at most this value.
- `ADDR_W` is derived as clog2(DEPTH); it is a localparam, not overridable.

Ports:
- `sys_clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `tx_ready` in 1: write request.
- `tx_data` in DATA_W: write data.
- `rx_ready` in 1: read request.
- `rx_data` out DATA_W: registered read data.
- `rx_valid` out 1: one-cycle strobe; `rx_data` was updated this cycle.
- `fifo_f` out 1: full.
- `fifo_e` out 1: empty.
- `fifo_af` out 1: almost full.
- `fifo_ae` out 1: almost empty.
- `fifo_cnt` out ADDR_W+1: occupancy, 0..DEPTH.
- `err_clr` in 1: clears sticky error flags.
- `ovf` out 1: sticky overflow.
- `udf` out 1: sticky underflow.

## Operation
- Storage is a DEPTH x DATA_W array; storage is not reset.
- `wr_ptr` and `rd_ptr` are ADDR_W+1 bits wide; the low ADDR_W bits address the array, and the MSB is the wrap bit.
- Wrap-around: a pointer at DEPTH-1 advances to index 0 and toggles its wrap bit. Pointer arithmetic is modulo 2^(ADDR_W+1).
- Write is accepted when `tx_ready && !fifo_f`:
  - `mem[wr_ptr] <= tx_data`.
  - `wr_ptr` increments.
- Read is accepted when `rx_ready && !fifo_e`:
  - `rx_data <= mem[rd_ptr]`.
  - `rx_valid <= 1`.
  - `rd_ptr` increments.
- Flag decisions use registered flags only. There is no fall-through, and no write-through-when-full.
  - Full with both requests: the read is accepted and the write is rejected.
  - Empty with both requests: the write is accepted and the read is rejected.
  - Both accepted: `fifo_cnt` is unchanged.
- Counter update: `fifo_cnt` +1 on write only, -1 on read only, unchanged otherwise.
- All flags are registered and computed from the next count:
  - `fifo_f` = (cnt==DEPTH).
  - `fifo_e` = (cnt==0).
  - `fifo_af` = (cnt>=AF_LEVEL).
  - `fifo_ae` = (cnt<=AE_LEVEL).
- `rx_data` holds its last value when no read is accepted. `rx_valid` is 0 in any cycle without an accepted read.
- Rejected requests leave pointers, storage and `fifo_cnt` untouched.

## Timing
- Every output changes only on the rising edge of `sys_clk`.
- Reset values (when `rst_n`=0 at an edge):
  - Pointers 0, `fifo_cnt` 0.
  - `fifo_e` 1, `fifo_f` 0, `fifo_ae` 1, `fifo_af` 0.
  - `rx_data` 0, `rx_valid` 0.
  - `ovf` 0, `udf` 0.
- Reset mid-operation: reset has priority over all requests in the same cycle and discards contents.
- Write latency: a write accepted at edge N updates `fifo_e`/`fifo_cnt` after edge N. The earliest read of that word is requested at edge N+1, with `rx_data` valid after edge N+1.
- Read latency: 1 cycle from the accepted request edge to `rx_data`/`rx_valid`.
- Sustained throughput is one write plus one read per cycle when neither full nor empty.

## Configuration
- Macro `SYNC_FIFO_ERR_EN`.
- Defined:
  - `ovf` sets at the edge where `tx_ready` is high while `fifo_f`=1, even if a simultaneous read is accepted.
  - `udf` sets at the edge where `rx_ready` is high while `fifo_e`=1.
  - Both flags stay set until `err_clr`=1 at an edge or reset.
  - When set and clear occur in the same cycle, set wins.
- Not defined: `ovf`/`udf` are tied to 0 and `err_clr` is ignored. Ports remain present so instantiations are unchanged.

## Test plan
All scenarios use DATA_W=8 and DEPTH=8, with AF_LEVEL and AE_LEVEL at their defaults.
- Reset then idle -> `fifo_e`=1, `fifo_f`=0, `fifo_cnt`=0, `rx_valid`=0, `rx_data`=0x00.
- Write 0x10..0x17 on 8 consecutive cycles:
  - `fifo_af` rises after the 7th write and `fifo_f` after the 8th; `fifo_cnt`=8.
  - A 9th write of 0xFF is rejected; `ovf`=1 with the macro.
  - 8 reads then return 0x10..0x17 in order, one per cycle, with `rx_valid` high each cycle; `fifo_e`=1 after the last.
- Wrap-around: write 5, read 5, then write 0xA0..0xA7 and read 8 -> data 0xA0..0xA7 in order; both pointer wrap bits are toggled; `fifo_cnt` returns to 0.
- Simultaneous requests:
  - With `fifo_cnt`=3 -> `fifo_cnt` stays 3 and data order is preserved.
  - Full -> the read is accepted and the write is rejected; `fifo_cnt`=7.
  - Empty -> the write is accepted and the read is rejected; `fifo_cnt`=1, `rx_valid`=0, `udf`=1 with the macro.
- Read while empty -> `rx_data` holds its previous value and `rx_valid`=0. `err_clr` pulse -> `udf`=0 next cycle; without the macro `udf` is 0 throughout.
- `rst_n` low for one cycle with `fifo_cnt`=5 while `tx_ready`=1 -> `fifo_cnt`=0 and `fifo_e`=1 after that edge; no write is accepted.
